// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle controller and the IFU next-PC select.
package mc_pkg;
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADD, C_SUB, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] JOP_PC4 = 3'd0;
    localparam logic [2:0] JOP_BEQ = 3'd1;
    localparam logic [2:0] JOP_JAL = 3'd2;
    localparam logic [2:0] JOP_JR  = 3'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies the opcode/funct fields of the instruction register.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);
    logic rtype;
    assign rtype = op == OP_RTYPE;
    assign cls = (rtype && funct == FN_ADD) ? C_ADD :
                 (rtype && funct == FN_SUB) ? C_SUB :
                 (rtype && funct == FN_JR)  ? C_JR  :
                 (op == OP_ORI)             ? C_ORI :
                 (op == OP_LUI)             ? C_LUI :
                 (op == OP_LW)              ? C_LW  :
                 (op == OP_SW)              ? C_SW  :
                 (op == OP_BEQ)             ? C_BEQ :
                 (op == OP_JAL)             ? C_JAL : C_NOP;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer driving the IFU next-PC interface and datapath enables.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC_NOTE = 32'h00003000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        irEn,
    output logic        pcEn,
    output logic [2:0]  jumpOp,
    output logic [15:0] offset,
    output logic [25:0] instr_index,
    output logic        regWrite,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic        memWrite,
    output logic [2:0]  aluOp,
    output logic        aluSrc,
    output logic        extOp,
    output logic [2:0]  state,
    output logic [31:0] retired
);
    state_t      cur, nxt;
    cls_t        cls;
    logic [31:0] ir;
    logic        done, act, unused_ok;

    // zero goes straight to the IFU; the PC note is informational only
    assign unused_ok = zero | (|RESET_PC_NOTE);

    mc_decode u_dec (.op(ir[31:26]), .funct(ir[5:0]), .cls(cls));

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_IF;
            ir      <= '0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_IF) ir <= instr;
            if (pcEn) retired <= retired + 32'd1;
        end
    end

    assign done = (cur == S_ID  && cls == C_NOP) ||
                  (cur == S_EX  && (cls == C_BEQ || cls == C_JR)) ||
                  (cur == S_MEM && cls == C_SW) ||
                  (cur == S_WB);

    always_comb begin
        nxt = S_IF;
        case (cur)
            S_IF:  nxt = S_ID;
            S_ID:  nxt = cls == C_JAL ? S_WB : S_EX;
            S_EX:  nxt = (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
            S_MEM: nxt = S_WB;
            default: nxt = S_IF;
        endcase
        if (done) nxt = S_IF;
    end

    // strobes are masked during reset so an interrupted instruction never commits
    always_comb begin
        act         = cur != S_IF;
        irEn        = cur == S_IF;
        pcEn        = done && !reset;
        jumpOp      = !pcEn          ? JOP_PC4 :
                      cls == C_BEQ   ? JOP_BEQ :
                      cls == C_JAL   ? JOP_JAL :
                      cls == C_JR    ? JOP_JR  : JOP_PC4;
        regWrite    = cur == S_WB && !reset;
        memWrite    = cur == S_MEM && cls == C_SW && !reset;
        aluOp       = !act                            ? ALU_ADD :
                      (cls == C_SUB || cls == C_BEQ)  ? ALU_SUB :
                      cls == C_ORI                    ? ALU_OR  :
                      cls == C_LUI                    ? ALU_LUI : ALU_ADD;
        aluSrc      = act && (cls == C_ORI || cls == C_LUI || cls == C_LW || cls == C_SW);
        extOp       = act && (cls == C_LW || cls == C_SW);
        regDst      = !act                            ? DST_RT :
                      (cls == C_ADD || cls == C_SUB)  ? DST_RD :
                      cls == C_JAL                    ? DST_RA : DST_RT;
        memToReg    = !act          ? WD_ALU :
                      cls == C_LW   ? WD_MEM :
                      cls == C_JAL  ? WD_PC4 : WD_ALU;
        offset      = ir[15:0];
        instr_index = ir[25:0];
        state       = cur;
    end
endmodule
